// File: rtl/mac_driver.sv
// mac_driver: streams a stored operand vector into an external MAC and
// captures the accumulated dot-product when the stream ends.
// Optional build macro MAC_DRV_CHECK_EN adds a shadow sum of the streamed
// products. At capture it flags a MAC result that disagrees with the shadow
// sum, or a MAC that is not asserting valid.
module mac_driver #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_a,
  input  logic [7:0]  wr_b,
  input  logic        start,
  input  logic [3:0]  len,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        mismatch,
  output logic        mac_enable,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  input  logic        mac_valid,
  input  logic [15:0] mac_c
);

  typedef enum logic [1:0] {IDLE, STREAM, CAPTURE} state_t;

  state_t      r_state;
  state_t      w_next;

  // Storage is sized for the largest legal DEPTH; slots at or above DEPTH
  // are never written and never read.
  logic [15:0] r_mem [8];

  logic [3:0]  r_idx;
  logic [3:0]  r_len;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic        r_mac_en;
  logic [7:0]  r_mac_a;
  logic [7:0]  r_mac_b;

  logic [3:0]  w_eff_len;
  logic        w_accept;
  logic        w_wr_ok;
  logic        w_step;
  logic [15:0] w_slot;
  logic [15:0] w_slot0;

  // A requested length longer than the storage is clamped to DEPTH.
  assign w_eff_len = (len > 4'(DEPTH)) ? 4'(DEPTH) : len;
  assign w_accept  = (r_state == IDLE) && start && (w_eff_len != 4'd0);
  // A write that coincides with an accepted start is dropped.
  assign w_wr_ok   = (r_state == IDLE) && wr_en && !w_accept &&
                     ({1'b0, wr_addr} < 4'(DEPTH));
  assign w_step    = (r_state == STREAM) && (r_idx < r_len);
  assign w_slot    = r_mem[r_idx[2:0]];
  assign w_slot0   = r_mem[0];

  // Host writes into operand memory (deliberately not reset)
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr] <= {wr_a, wr_b};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // FSM next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = STREAM;
      STREAM:  if (!w_step)  w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs: operand streaming, result capture and handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx    <= 4'd0;
      r_len    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'd0;
      r_mac_en <= 1'b0;
      r_mac_a  <= 8'd0;
      r_mac_b  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_mac_en <= 1'b1;
            r_mac_a  <= w_slot0[15:8];
            r_mac_b  <= w_slot0[7:0];
            r_idx    <= 4'd1;
            r_len    <= w_eff_len;
          end
        end
        STREAM: begin
          if (w_step) begin
            r_mac_a <= w_slot[15:8];
            r_mac_b <= w_slot[7:0];
            r_idx   <= r_idx + 4'd1;
          end else begin
            r_mac_en <= 1'b0;
            r_mac_a  <= 8'd0;
            r_mac_b  <= 8'd0;
          end
        end
        CAPTURE: begin
          r_result <= mac_c;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_idx    <= 4'd0;
        end
        default: begin
          r_busy   <= 1'b0;
          r_mac_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign mac_enable = r_mac_en;
  assign mac_a      = r_mac_a;
  assign mac_b      = r_mac_b;

`ifdef MAC_DRV_CHECK_EN
  logic [15:0] r_shadow;
  logic        r_mismatch;

  // Product of one stored pair, wrapped to 16 bits like the MAC.
  function automatic logic [15:0] pair_prod(input logic [15:0] pair);
    return 16'(pair[15:8]) * 16'(pair[7:0]);
  endfunction

  // Shadow accumulation of streamed products and compare at capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow   <= 16'd0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept)    r_shadow <= pair_prod(w_slot0);
      else if (w_step) r_shadow <= r_shadow + pair_prod(w_slot);
      if (r_state == CAPTURE) r_mismatch <= (mac_c != r_shadow) || !mac_valid;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_mac_valid;
  assign w_unused_mac_valid = mac_valid;
  assign mismatch           = 1'b0;
`endif

endmodule

// File: tb/tb_mac_driver.sv
// Self-checking bench for mac_driver with a behavioural MAC stub and a
// dot-product reference model derived from the written operand slots.
module tb_mac_driver;
  localparam int DEPTH = 8;
`ifdef MAC_DRV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_a, wr_b;
  logic        start;
  logic [3:0]  len;
  logic        busy, done, mismatch, mac_enable;
  logic [15:0] result;
  logic [7:0]  mac_a, mac_b;
  logic        mac_valid;
  logic [15:0] mac_c;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [8];
  logic        force_zero = 1'b0;
  logic [15:0] mac_acc;
  logic        mac_prev_en;

  always #5 clk = ~clk;

  mac_driver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .start(start), .len(len), .busy(busy),
    .done(done), .result(result), .mismatch(mismatch),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(mac_valid), .mac_c(mac_c)
  );

  // External MAC stub: accumulates a*b on every enabled cycle, restarting
  // the sum at the first enabled cycle of each burst.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_acc     <= 16'd0;
      mac_prev_en <= 1'b0;
    end else begin
      mac_prev_en <= mac_enable;
      if (mac_enable)
        mac_acc <= (mac_prev_en ? mac_acc : 16'd0) + 16'(mac_a) * 16'(mac_b);
    end
  end
  assign mac_c     = force_zero ? 16'd0 : mac_acc;
  assign mac_valid = 1'b1;

  function automatic int eff_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [15:0] ref_dot(input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) s += ref_mem[i][15:8] * ref_mem[i][7:0];
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int addr, input logic [7:0] a, input logic [7:0] b);
    wr_en = 1'b1; wr_addr = addr[2:0]; wr_a = a; wr_b = b;
    tick();
    wr_en = 1'b0;
    if (addr < DEPTH) ref_mem[addr] = {a, b};
  endtask

  // Launch one run and follow it to done; returns on the cycle done is high.
  task automatic run(input int l, input logic zero_res, input logic exp_mm,
                     input logic inject);
    int n = eff_len(l);
    logic [15:0] exp = zero_res ? 16'd0 : ref_dot(n);
    logic [15:0] s0 = ref_mem[0];
    int cyc = 0;
    int en = 1;
    start = 1'b1; len = l[3:0];
    tick();
    start = 1'b0; wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || mac_enable !== 1'b1 || {mac_a, mac_b} !== s0) begin
      errors++;
      $display("FAIL e0_accept busy=%b en=%b ab=%h required 1 1 %h", busy, mac_enable, {mac_a, mac_b}, s0);
    end
    while (cyc < 40) begin
      tick();
      cyc++;
      if (inject && cyc == 1) begin
        start = 1'b1; len = 4'd15;
        wr_en = 1'b1; wr_addr = 3'd0; wr_a = 8'($urandom); wr_b = 8'($urandom);
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (mac_enable) en++;
      if (done) break;
      if (busy !== 1'b1) begin
        errors++; checks++;
        $display("FAIL busy_drop cycle=%0d busy=%b required 1", cyc, busy);
      end
    end
    start = 1'b0; wr_en = 1'b0;
    checks++;
    if (cyc !== n + 1) begin
      errors++; $display("FAIL done_latency got=%0d required=%0d", cyc, n + 1);
    end
    checks++;
    if (en !== n) begin
      errors++; $display("FAIL enable_cycles got=%0d required=%0d", en, n);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL result len=%0d got=%0d required=%0d", l, result, exp);
    end
    checks++;
    if (mismatch !== exp_mm || busy !== 1'b0) begin
      errors++; $display("FAIL capture_flags mismatch=%b busy=%b required %b 0", mismatch, busy, exp_mm);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; len = '0;
    #3;
    checks++;
    if ({busy, done, mismatch, mac_enable, mac_a, mac_b, result} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {busy, done, mismatch, mac_enable, mac_a, mac_b, result});
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_slot(i, 8'd0, 8'd0);
  endtask

  task automatic test_single();
    write_slot(0, 8'd2, 8'd2);
    run(1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (result !== 16'd4) begin
      errors++; $display("FAIL single_value got=%0d required=4", result);
    end
    tick();
    checks++;
    if (done !== 1'b0 || result !== 16'd4) begin
      errors++; $display("FAIL done_pulse_hold done=%b result=%0d required 0 4", done, result);
    end
  endtask

  task automatic test_three();
    write_slot(0, 8'd2, 8'd2); write_slot(1, 8'd3, 8'd3); write_slot(2, 8'd4, 8'd4);
    run(3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (result !== 16'd29) begin
      errors++; $display("FAIL three_value got=%0d required=29", result);
    end
    tick();
  endtask

  task automatic test_clamp();
    for (int i = 0; i < DEPTH; i++) write_slot(i, 8'd255, 8'd255);
    run(15, 1'b0, 1'b0, 1'b0);
    checks++;
    if (result !== 16'd61448) begin
      errors++; $display("FAIL clamp_value got=%0d required=61448", result);
    end
    tick();
  endtask

  task automatic test_ignored();
    write_slot(0, 8'd5, 8'd6); write_slot(1, 8'd7, 8'd8); write_slot(2, 8'd9, 8'd10);
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mac_enable !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_len_start busy=%b en=%b done=%b required 0 0 0", busy, mac_enable, done);
    end
    // write presented together with an accepted start is dropped
    wr_en = 1'b1; wr_addr = 3'd1; wr_a = 8'd99; wr_b = 8'd99;
    run(2, 1'b0, 1'b0, 1'b0);
    tick();
    // start and write while busy are ignored
    run(3, 1'b0, 1'b0, 1'b1);
    tick();
    run(3, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    write_slot(0, 8'd11, 8'd3); write_slot(1, 8'd200, 8'd201);
    write_slot(2, 8'd17, 8'd19); write_slot(3, 8'd1, 8'd250);
    run(2, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    write_slot(0, 8'd1, 8'd2); write_slot(1, 8'd3, 8'd4);
    write_slot(2, 8'd5, 8'd6); write_slot(3, 8'd7, 8'd8);
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (mac_enable !== 1'b0 || busy !== 1'b0 || {mac_a, mac_b} !== 16'd0) begin
      errors++; $display("FAIL midreset_outputs en=%b busy=%b ab=%h required 0 0 0", mac_enable, busy, {mac_a, mac_b});
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_no_done pulses=%0d required=0", seen);
    end
    for (int i = 0; i < DEPTH; i++) write_slot(i, 8'(i + 1), 8'(2 * i + 3));
    run(4, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_force_zero();
    write_slot(0, 8'd2, 8'd2);
    force_zero = 1'b1;
    run(1, 1'b1, CHK, 1'b0);
    force_zero = 1'b0;
    tick();
    run(1, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      int nw = $urandom_range(1, 4);
      int l;
      for (int k = 0; k < nw; k++)
        write_slot($urandom_range(0, 7), 8'($urandom), 8'($urandom));
      l = $urandom_range(0, 15);
      if (eff_len(l) == 0) begin
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || mac_enable !== 1'b0) begin
          errors++; $display("FAIL rand_zero_len busy=%b en=%b required 0 0", busy, mac_enable);
        end
      end else begin
        run(l, 1'b0, 1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_clamp();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_force_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
